// File: rtl/imm_encoder.sv
// imm_encoder: packs an immediate into RISC-V I/S/B/J fields of a base word, flags unencodable values, queues results in a FIFO
module imm_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_fmt,
  input  logic             in_sign,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]      mem_q [DEPTH];
  logic             err_mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic [31:0]      mask, field, inst_d;
  logic             sg_bad, us_bad, err_d, push, pop;
  assign in_ready  = cnt_q < CW'(DEPTH);
  assign out_valid = cnt_q != '0;
  assign out_inst  = out_valid ? mem_q[rd_q] : '0;
  assign out_err   = out_valid & err_mem_q[rd_q];
  assign err_cnt   = ecnt_q;
  always_comb begin
    sg_bad = in_fmt == 2'b11 ? ~(&in_imm[31:20] | ~|in_imm[31:20]) :
             in_fmt == 2'b10 ? ~(&in_imm[31:12] | ~|in_imm[31:12]) :
                               ~(&in_imm[31:11] | ~|in_imm[31:11]);
    us_bad = in_fmt == 2'b11 ? |in_imm[31:21] :
             in_fmt == 2'b10 ? |in_imm[31:13] : |in_imm[31:12];
    err_d  = (in_sign ? sg_bad : us_bad) | (in_fmt[1] & in_imm[0]);
    mask   = in_fmt == 2'b00 ? 32'hFFF0_0000 :
             in_fmt == 2'b11 ? 32'hFFFF_F000 : 32'hFE00_0F80;
    field  = in_fmt == 2'b00 ? {in_imm[11:0], 20'b0} :
             in_fmt == 2'b01 ? {in_imm[11:5], 13'b0, in_imm[4:0], 7'b0} :
             in_fmt == 2'b10 ? {in_imm[12], in_imm[10:5], 13'b0, in_imm[4:1], in_imm[11], 7'b0} :
                               {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'b0};
    inst_d = (in_base & ~mask) | field;
    push   = in_valid & in_ready;
    pop    = out_valid & out_ready;
    wr_d   = wr_q + AW'(push);
    rd_d   = rd_q + AW'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    ecnt_d = ecnt_q + CNT_W'(push & err_d & ~&ecnt_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      ecnt_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      ecnt_q <= ecnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q]     <= inst_d;
      err_mem_q[wr_q] <= err_d;
    end
  end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: randomized scoreboard bench for imm_encoder with directed corner cases
module tb_imm_encoder;
  localparam int MAXC = 65535;
  logic        clk = 0, rst = 1, in_valid = 0, in_sign = 0, out_ready = 0;
  logic [1:0]  in_fmt = 0;
  logic [31:0] in_imm = 0, in_base = 0;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_inst;
  logic [15:0] err_cnt;
  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic [31:0] imm;
    logic [1:0]  fmt;
    logic        sign;
  } ent_t;
  ent_t        q[$];
  logic [31:0] popped[$];
  int          mcnt = 0, n_chk = 0, n_fail = 0;
  bit          last_acc;
  imm_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_sign(in_sign), .in_imm(in_imm), .in_base(in_base), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  function automatic int fw(logic [1:0] f);
    return f == 3 ? 21 : f == 2 ? 13 : 12;
  endfunction
  function automatic logic model_err(logic [1:0] f, logic s, logic [31:0] imm);
    longint one = 1, v;
    int w = fw(f);
    bit bad;
    if (s) begin
      v = longint'($signed(imm));
      bad = v < -(one << (w - 1)) || v >= (one << (w - 1));
    end else begin
      v = longint'({32'b0, imm});
      bad = v >= (one << w);
    end
    return bad || (f >= 2 && imm[0]);
  endfunction
  function automatic logic [31:0] model_inst(logic [1:0] f, logic [31:0] imm, logic [31:0] base);
    logic [31:0] r;
    case (f)
      2'd0: begin r = base & 32'h000F_FFFF; r[31:20] = imm[11:0]; end
      2'd1: begin r = base & 32'h01FF_F07F; r[31:25] = imm[11:5]; r[11:7] = imm[4:0]; end
      2'd2: begin
        r = base & 32'h01FF_F07F;
        r[31] = imm[12]; r[30:25] = imm[10:5]; r[11:8] = imm[4:1]; r[7] = imm[11];
      end
      default: begin
        r = base & 32'h0000_0FFF;
        r[31] = imm[20]; r[30:21] = imm[10:1]; r[20] = imm[11]; r[19:12] = imm[19:12];
      end
    endcase
    return r;
  endfunction
  function automatic logic [31:0] decode(logic [31:0] i, logic [1:0] f, logic s);
    logic [31:0] v;
    int w = fw(f);
    case (f)
      2'd0: v = {20'b0, i[31:20]};
      2'd1: v = {20'b0, i[31:25], i[11:7]};
      2'd2: v = {19'b0, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: v = {11'b0, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
    if (s) v = $signed(v << (32 - w)) >>> (32 - w);
    return v;
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle();
    bit pp;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("err_cnt", 32'(err_cnt), 32'(mcnt));
    if (q.size() != 0) begin
      check("inst", out_inst, q[0].inst);
      check("err", 32'(out_err), 32'(q[0].err));
      if (!q[0].err) check("round_trip", decode(out_inst, q[0].fmt, q[0].sign), q[0].imm);
    end
    last_acc = in_valid && in_ready;
    pp = out_valid && out_ready;
    if (pp && !rst) popped.push_back(out_inst);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (pp) void'(q.pop_front());
      if (last_acc) begin
        ent_t e;
        e.inst = model_inst(in_fmt, in_imm, in_base);
        e.err  = model_err(in_fmt, in_sign, in_imm);
        e.imm = in_imm; e.fmt = in_fmt; e.sign = in_sign;
        q.push_back(e);
        if (e.err && mcnt < MAXC) mcnt++;
      end
    end
  endtask
  task automatic send(logic [1:0] f, logic s, logic [31:0] imm, logic [31:0] base);
    in_fmt = f; in_sign = s; in_imm = imm; in_base = base; in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) check("send_timeout", 0, 1);
    in_valid = 0;
  endtask
  task automatic expect_head(string tag, logic [31:0] inst, logic err);
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_inst"}, out_inst, inst);
    check({tag, "_err"}, 32'(out_err), 32'(err));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_inst", out_inst, 0);
    check("rst_err", 32'(out_err), 0);
    check("rst_cnt", 32'(err_cnt), 0);
    check("rst_ready", 32'(in_ready), 1);
    out_ready = 1;
    send(0, 1, 32'hFFFF_FFFF, 32'h0000_0013); expect_head("i_neg", 32'hFFF0_0013, 0);
    send(0, 0, 32'h0000_1000, 32'h0000_0013); expect_head("i_uns_ovf", 32'h0000_0013, 1);
    check("cnt_one", 32'(err_cnt), 1);
    send(1, 1, 32'hFFFF_FFF8, 32'h0000_2023); expect_head("s_neg", 32'hFE00_2C23, 0);
    send(2, 1, 32'hFFFF_FFFC, 32'h0000_0063); expect_head("b_neg", 32'hFE00_0EE3, 0);
    send(3, 1, 32'h0000_0008, 32'h0000_006F); expect_head("j_pos", 32'h0080_006F, 0);
    send(3, 1, 32'h0010_0000, 32'h0000_006F); check("j_ovf_err", 32'(out_err), 1);
    send(2, 1, 32'h0000_0005, 32'h0000_0063); check("b_align_err", 32'(out_err), 1);
    repeat (3) cycle();
    check("cnt_three", 32'(err_cnt), 3);
    out_ready = 0;
    popped.delete();
    in_fmt = 0; in_sign = 1; in_base = 32'h13; in_valid = 1;
    for (int k = 1; k <= 3; k++) begin
      in_imm = k;
      cycle();
    end
    check("full_ready", 32'(in_ready), 0);
    check("third_held", 32'(last_acc), 0);
    out_ready = 1;
    for (int i = 0; i < 10 && !last_acc; i++) cycle();
    if (!last_acc) check("third_timeout", 0, 1);
    in_valid = 0;
    repeat (5) cycle();
    check("drain_count", popped.size(), 3);
    for (int k = 0; k < 3 && k < popped.size(); k++) check("drain_order", popped[k], 32'h13 | ((k + 1) << 20));
    for (int i = 0; i < 3000; i++) begin
      int sh;
      sh = $urandom_range(10, 31);
      out_ready = $urandom_range(0, 3) != 0;
      in_valid  = $urandom_range(0, 3) != 0;
      in_fmt    = 2'($urandom_range(0, 3));
      in_sign   = 1'($urandom_range(0, 1));
      in_base   = $urandom;
      case ($urandom_range(0, 2))
        0: in_imm = $urandom;
        1: in_imm = $urandom >> sh;
        default: in_imm = -($urandom >> sh);
      endcase
      cycle();
    end
    in_valid = 0; out_ready = 1;
    repeat (5) cycle();
    out_ready = 0; in_fmt = 2; in_sign = 1; in_imm = 32'h7; in_valid = 1;
    repeat (3) cycle();
    in_valid = 0;
    check("pre_rst_valid", 32'(out_valid), 1);
    rst = 1;
    cycle();
    rst = 0;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_cnt", 32'(err_cnt), 0);
    check("mid_rst_ready", 32'(in_ready), 1);
    out_ready = 1; in_fmt = 0; in_sign = 0; in_imm = 32'h1000; in_base = 32'h13; in_valid = 1;
    repeat (MAXC + 5) cycle();
    in_valid = 0;
    check("sat_cnt", 32'(err_cnt), 32'hFFFF);
    repeat (3) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the pipeline's immediate generator: takes a 32-bit immediate, a format select and a base instruction word, and packs the immediate into the RISC-V I/S/B/J bit positions.
- Checks that the immediate is encodable and emits the assembled word through a small output FIFO with valid/ready handshakes.
- Used by the test-program loader and the self-check harness. Feeding out_inst back through the immediate generator with the same fmt/sign returns in_imm whenever out_err=0.

Parameters:
- DEPTH, 2, output FIFO entries (power of 2, ≥2)
- CNT_W, 16, width of the saturating error counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request this cycle
- in_fmt  input  2  00=I, 01=S, 10=B, 11=J (same encoding as the immediate generator's select)
- in_sign  input  1  1=signed range check, 0=unsigned (zero-extended) range check
- in_imm  input  32  immediate value to encode
- in_base  input  32  instruction with opcode/rd/rs/funct fields; its immediate-field bits are ignored
- out_valid  output  1  out_inst/out_err valid
- out_ready  input  1  consumer accepts the head word
- out_inst  output  32  assembled instruction
- out_err  output  1  immediate was not encodable; word still emitted
- err_cnt  output  CNT_W  count of accepted requests with error, saturating

Behaviour:
- Reset (rst=1 at a posedge) gives: out_valid=0, out_inst=0, out_err=0, err_cnt=0, FIFO empty. Reset mid-operation discards all queued words; the in-flight handshake is dropped.
- Immediate-field masks, cleared in in_base before packing:
  - I: [31:20]
  - S and B: [31:25] and [11:7]
  - J: [31:12]
  - All other in_base bits pass through unchanged.
- Packing:
  - I: inst[31:20]=imm[11:0]
  - S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]
  - B: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11]
  - J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12]
- Error (out_err=1) conditions:
  - Signed checks (imm bits must all equal the sign bit):
    - I/S: imm[31:11] not all equal
    - B: imm[31:12] not all equal
    - J: imm[31:20] not all equal
  - Unsigned checks (high bits must be zero):
    - I/S: imm[31:12]≠0
    - B: imm[31:13]≠0
    - J: imm[31:21]≠0
  - Alignment, either signedness: B or J with imm[0]=1.
  - On error, the truncated bits are still packed as above.
- Handshake:
  - Accept when in_valid & in_ready. in_ready = (FIFO count < DEPTH); this is a registered count, with no same-cycle pass-through when full.
  - An accepted request is encoded combinationally and written to the FIFO at that edge. out_valid=1 from the next cycle, so latency is 1 cycle when the FIFO is empty.
  - Pop when out_valid & out_ready. out_inst/out_err show the FIFO head and hold stable while out_valid=1 and out_ready=0.
  - Simultaneous push and pop (non-full, non-empty): count unchanged, order preserved.
  - Push into an empty FIFO with out_ready=1: the word is not visible until the next cycle.
  - Requests are never dropped; the output is strictly FIFO.
- err_cnt increments at the accept edge of each erroring request and saturates at all-ones.

Test Plan:
- Reset, then I, sign=1, imm=0xFFFFFFFF, base=0x00000013 → one cycle later out_valid=1, out_inst=0xFFF00013, out_err=0. I, sign=0, imm=0x00001000 → out_inst=0x00000013, out_err=1, err_cnt=1.
- S, sign=1, imm=0xFFFFFFF8, base=0x00002023 → 0xFE002C23, err=0. B, sign=1, imm=0xFFFFFFFC, base=0x00000063 → 0xFE000EE3, err=0.
- J, sign=1, imm=0x00000008, base=0x0000006F → 0x0080006F, err=0. J, imm=0x00100000 → err=1. B, imm=0x00000005 → err=1 (misaligned).
- out_ready=0, issue 3 back-to-back requests → in_ready=0 after 2 accepts, third held. Raise out_ready → all 3 words emerge in order, with no loss or duplication.
- Random fmt/sign/imm with continuous traffic and random out_ready → scoreboard checks packing, err flag, err_cnt. Round-trip through the immediate generator equals imm when err=0.
- Assert rst with 2 words queued → next cycle out_valid=0, err_cnt=0, in_ready=1. Force 0xFFFF+ errors → err_cnt holds 0xFFFF.
